disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan controller for N_DIGITS multiplexed 7-segment digits.
// A line buffer of N_DIGITS ASCII characters is fed from a UART receiver. buf[0]
// holds the newest character. Each digit visit has three parts: a one-cycle
// BLANK, a one-cycle LOAD that strobes the character into the downstream codec,
// and a SHOW that lasts REFRESH_DIV cycles with that digit's anode enabled.
// Optional macro DISP_SPACE_BLANK_EN keeps the anodes dark while a space is
// shown. FSM timing does not change when the macro is defined.
module disp_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                clr,
    output logic [7:0]          char_out,
    output logic                char_stb,
    output logic [N_DIGITS-1:0] an,
    output logic [2:0]          digit_idx
);
    localparam int                  CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]       CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [2:0]          IDX_MAX  = 3'(N_DIGITS - 1);
    localparam logic [7:0]          SPACE    = 8'h20;
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{1'b1}};
    localparam logic [N_DIGITS-1:0] AN_SEL0  = {{(N_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                first_r, first_s;
    logic [2:0]          idx_r, idx_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [7:0]          char_r, char_s;
    logic                stb_r, stb_s;
    logic [N_DIGITS-1:0] an_r, an_s;
    logic [N_DIGITS-1:0] show_an_s;
    logic [7:0]          load_char_s;
    logic [7:0]          char_buf_r [N_DIGITS];
    logic [7:0]          buf_s      [N_DIGITS];

    // Scan sequencing. The index moves on BLANK exit. The first BLANK after reset does not move it.
    always_comb begin
        state_s = state_r;
        first_s = first_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_BLANK: begin
                state_s = ST_LOAD;
                first_s = 1'b0;
                cnt_s   = CNT_ZERO;
                if (first_r) begin
                    idx_s = idx_r;
                end else if (idx_r >= IDX_MAX) begin
                    idx_s = 3'd0;
                end else begin
                    idx_s = idx_r + 3'd1;
                end
            end
            ST_LOAD: begin
                state_s = ST_SHOW;
                cnt_s   = CNT_ZERO;
            end
            ST_SHOW: begin
                if (cnt_r == CNT_MAX) begin
                    state_s = ST_BLANK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_SHOW;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_BLANK;
                first_s = 1'b1;
                idx_s   = 3'd0;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Next buffer contents. A clear beats a received byte. A byte shifts the line toward higher indices.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            buf_s[i] = char_buf_r[i];
        end
        if (clr) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                buf_s[i] = SPACE;
            end
        end else if (rx_done) begin
            buf_s[0] = rx_data;
            for (int i = 1; i < N_DIGITS; i++) begin
                buf_s[i] = char_buf_r[i-1];
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                buf_s[i] = char_buf_r[i];
            end
        end
    end

    // Character for the digit being loaded. It includes a byte arriving on the same edge.
    always_comb begin
        load_char_s = SPACE;
        for (int i = 0; i < N_DIGITS; i++) begin
            load_char_s = (idx_s == 3'(i)) ? buf_s[i] : load_char_s;
        end
    end

    // Anode pattern while showing. The character is stable through SHOW, so char_r is used.
    always_comb begin
`ifdef DISP_SPACE_BLANK_EN
        show_an_s = (char_r == SPACE) ? AN_OFF : ~(AN_SEL0 << idx_r);
`else
        show_an_s = ~(AN_SEL0 << idx_r);
`endif
    end

    // Output values for the state entered on the next edge.
    always_comb begin
        char_s = char_r;
        stb_s  = 1'b0;
        an_s   = AN_OFF;
        case (state_s)
            ST_BLANK: an_s = AN_OFF;
            ST_LOAD: begin
                char_s = load_char_s;
                stb_s  = 1'b1;
            end
            ST_SHOW:  an_s = show_an_s;
            default:  an_s = AN_OFF;
        endcase
    end

    // State, buffer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BLANK;
            first_r <= 1'b1;
            idx_r   <= 3'd0;
            cnt_r   <= CNT_ZERO;
            char_r  <= SPACE;
            stb_r   <= 1'b0;
            an_r    <= AN_OFF;
            for (int i = 0; i < N_DIGITS; i++) begin
                char_buf_r[i] <= SPACE;
            end
        end else begin
            state_r <= state_s;
            first_r <= first_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            char_r  <= char_s;
            stb_r   <= stb_s;
            an_r    <= an_s;
            for (int i = 0; i < N_DIGITS; i++) begin
                char_buf_r[i] <= buf_s[i];
            end
        end
    end

    assign char_out  = char_r;
    assign char_stb  = stb_r;
    assign an        = an_r;
    assign digit_idx = idx_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: random and directed stimulus for disp_scan_ctrl.
// The model keeps a cycle count since reset and a character queue. Each expected
// output is derived from the visit timing with plain arithmetic.
module tb_disp_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int VISIT = RD + 2;
`ifdef DISP_SPACE_BLANK_EN
    localparam bit SPACE_BLANK = 1'b1;
`else
    localparam bit SPACE_BLANK = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          clr;
    logic [7:0]    char_out;
    logic          char_stb;
    logic [ND-1:0] an;
    logic [2:0]    digit_idx;

    int         checks;
    int         errors;
    bit         chk_en;
    int         t_m;
    logic [7:0] mchar;
    logic [7:0] mq [$];

    disp_scan_ctrl #(.N_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .clr(clr),
        .char_out(char_out), .char_stb(char_stb), .an(an), .digit_idx(digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit index for cycle t after reset release.
    function automatic int dig(input int t);
        if (t == 0) return 0;
        return ((t - 1) / VISIT) % ND;
    endfunction

    // Expected anodes for cycle t.
    function automatic logic [ND-1:0] exp_an_f(input int t, input logic [7:0] ch);
        logic [ND-1:0] a;
        a = '1;
        if ((t % VISIT) >= 2) a[dig(t)] = 1'b0;
        if (SPACE_BLANK && ch == 8'h20) a = '1;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs the DUT sampled.
    task automatic model_edge();
        if (reset) begin
            t_m   = 0;
            mchar = 8'h20;
            mq.delete();
            for (int i = 0; i < ND; i++) mq.push_back(8'h20);
        end else begin
            if (clr) begin
                for (int i = 0; i < ND; i++) mq[i] = 8'h20;
            end else if (rx_done) begin
                mq.push_front(rx_data);
                void'(mq.pop_back());
            end
            t_m++;
            if ((t_m % VISIT) == 1) mchar = mq[dig(t_m)];
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [7:0] d, input logic c);
        @(negedge clk);
        reset = r; rx_done = rd; rx_data = d; clr = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_to_load(input int d);
        int n;
        n = 0;
        do begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end while (!(((t_m % VISIT) == 1) && (dig(t_m) == d)) && n < 200);
        check("load_reach", (n < 200), 1'b1);
    endtask

    // Check the DUT against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("an", an, exp_an_f(t_m, mchar));
            check("char_stb", char_stb, ((t_m % VISIT) == 1));
            check("digit_idx", digit_idx, dig(t_m));
            check("char_out", char_out, mchar);
            check("an_one_low", ($countones(~an) <= 1), 1'b1);
        end
    end

    initial begin
        reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; clr = 1'b0;
        checks = 0; errors = 0; chk_en = 1'b0; t_m = 0; mchar = 8'h20;

        // Reset with rx_done and clr pulsed. Both must be ignored.
        cyc(1'b1, 1'b1, 8'h33, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b1, 8'h34, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("rst_an", an, 4'b1111);
        check("rst_idx", digit_idx, 3'd0);
        check("rst_stb", char_stb, 1'b0);
        check("rst_char", char_out, 8'h20);

        // Timing of the first frame after reset release.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("c1_stb", char_stb, 1'b1);
        check("c1_idx", digit_idx, 3'd0);
        check("c1_an", an, 4'b1111);
        for (int k = 2; k <= 5; k++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            check("c2_5_an", an, SPACE_BLANK ? 4'b1111 : 4'b1110);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("c6_an", an, 4'b1111);
        check("c6_idx", digit_idx, 3'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("c7_stb", char_stb, 1'b1);
        check("c7_idx", digit_idx, 3'd1);

        // Shift in A, B, C. Each digit LOAD then reads back its buffer entry.
        cyc(1'b0, 1'b1, 8'h41, 1'b0);
        cyc(1'b0, 1'b1, 8'h42, 1'b0);
        cyc(1'b0, 1'b1, 8'h43, 1'b0);
        run_to_load(0); check("abc_d0", char_out, 8'h43);
        run_to_load(1); check("abc_d1", char_out, 8'h42);
        run_to_load(2); check("abc_d2", char_out, 8'h41);
        run_to_load(3); check("abc_d3", char_out, 8'h20);

        // clr and rx_done in the same cycle. clr wins.
        cyc(1'b0, 1'b1, 8'h5A, 1'b1);
        for (int d = 0; d < ND; d++) begin
            run_to_load(d);
            check("clr_wins", char_out, 8'h20);
        end

        // A byte received mid-SHOW shows up only on that digit's next LOAD.
        cyc(1'b0, 1'b1, 8'h41, 1'b0);
        run_to_load(0);
        check("pre_char", char_out, 8'h41);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        check("mid_show_hold", char_out, 8'h41);
        repeat (22) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("next_load_stb", char_stb, 1'b1);
        check("next_load_idx", digit_idx, 3'd0);
        check("next_load_char", char_out, 8'h55);

        // Reset asserted during SHOW of digit 2.
        run_to_load(2);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("d2_show_an", an, SPACE_BLANK ? 4'b1111 : 4'b1011);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("midrst_an", an, 4'b1111);
        check("midrst_idx", digit_idx, 3'd0);
        check("midrst_stb", char_stb, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("post_rst_stb", char_stb, 1'b1);
        check("post_rst_idx", digit_idx, 3'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                8'($urandom_range(32, 126)), ($urandom_range(0, 39) == 0));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
